// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the ID/EX register, the execute ALU and EX/MEM.
// The master side issues operations and accepts results; the slave side is the ALU.
interface alu_exec_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            Operation;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  Zero;
    logic                  busy;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, busy
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered result/Zero and valid/ready handshakes; shifts run
// one bit per cycle unless ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter.
//
//   state | meaning
//   ------+------------------------------------------
//   IDLE  | no shift in progress, may accept requests
//   SHIFT | serial shift in progress, busy=1
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_unit_if.slave  bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1100;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q, state_d;
    logic                   out_valid_q;
    logic                   zero_q;
    logic [DATA_WIDTH-1:0]  result_q;
    logic [DATA_WIDTH-1:0]  imm_result;
    logic [DATA_WIDTH-1:0]  shift_next;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   in_ready_int;
    logic                   busy_int;
    logic                   accept;
    logic                   start_shift;
    logic                   shift_done;

    assign shamt  = bus.SrcB[SHAMT_WIDTH-1:0];
    assign accept = bus.in_valid && in_ready_int;

    // Result of every operation that finishes at its acceptance edge.
    always_comb begin
        imm_result = '0;
        case (bus.Operation)
            OP_AND: imm_result = bus.SrcA & bus.SrcB;
            OP_OR:  imm_result = bus.SrcA | bus.SrcB;
            OP_ADD: imm_result = bus.SrcA + bus.SrcB;
            OP_XOR: imm_result = bus.SrcA ^ bus.SrcB;
            OP_SUB: imm_result = bus.SrcA - bus.SrcB;
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL: imm_result = bus.SrcA << shamt;
            OP_SRL: imm_result = bus.SrcA >> shamt;
            OP_SRA: imm_result = $unsigned($signed(bus.SrcA) >>> shamt);
`else
            OP_SLL: imm_result = bus.SrcA;
            OP_SRL: imm_result = bus.SrcA;
            OP_SRA: imm_result = bus.SrcA;
`endif
            OP_EQ:  imm_result = (bus.SrcA == bus.SrcB) ? '0 : {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            OP_SLT: imm_result = {{(DATA_WIDTH-1){1'b0}},
                                  ($signed(bus.SrcA) < $signed(bus.SrcB))};
            default: imm_result = '0;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    assign start_shift = 1'b0;
    assign shift_done  = 1'b0;
    assign shift_next  = '0;
`else
    logic                   is_shift;
    logic [DATA_WIDTH-1:0]  work_q;
    logic [SHAMT_WIDTH-1:0] cnt_q;
    logic [1:0]             sop_q;

    assign is_shift    = (bus.Operation == OP_SLL) || (bus.Operation == OP_SRL) ||
                         (bus.Operation == OP_SRA);
    assign start_shift = accept && is_shift && (shamt != '0);
    assign shift_done  = (state_q == SHIFT) && (cnt_q == SHAMT_WIDTH'(1));

    // sop_q holds Operation[1:0]: 00 SLL, 01 SRL, 11 SRA.
    always_comb begin
        shift_next = work_q;
        case (sop_q)
            2'b00:   shift_next = {work_q[DATA_WIDTH-2:0], 1'b0};
            2'b01:   shift_next = {1'b0, work_q[DATA_WIDTH-1:1]};
            default: shift_next = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
        endcase
    end

    // Shift count is a down-counter; terminal count 1 completes the shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q <= '0;
            cnt_q  <= '0;
            sop_q  <= 2'b00;
        end else if (accept && is_shift) begin
            work_q <= bus.SrcA;
            cnt_q  <= shamt;
            sop_q  <= bus.Operation[1:0];
        end else if (state_q == SHIFT) begin
            work_q <= shift_next;
            cnt_q  <= cnt_q - SHAMT_WIDTH'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_shift) state_d = SHIFT;
            SHIFT:   if (shift_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_int = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
`ifdef ALU_FAST_SHIFT_EN
        busy_int     = 1'b0;
`else
        busy_int     = (state_q == SHIFT);
`endif
    end

    // A new result takes priority over draining the old one, so out_valid stays high.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
        end else if (accept && !start_shift) begin
            out_valid_q <= 1'b1;
            result_q    <= imm_result;
            zero_q      <= (imm_result == '0);
        end else if (shift_done) begin
            out_valid_q <= 1'b1;
            result_q    <= shift_next;
            zero_q      <= (shift_next == '0);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.busy      = busy_int;
    assign bus.out_valid = out_valid_q;
    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 4-bit `Operation` code produced by the ALU controller, together with two operands.
- Returns a registered result and a zero flag through a valid/ready handshake.
- Shifts run serially, one bit per cycle, to save area. All other operations complete in one cycle.
- Sits between the ID/EX pipeline register and the EX/MEM register. It drives the pipeline stall through `in_ready`.

Parameters:
- DATA_WIDTH, 32, operand and result width in bits.
- SHAMT_WIDTH, 5, shift-amount width; the shift amount is `SrcB[SHAMT_WIDTH-1:0]`.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request this cycle.
- Operation  input  4  operation code from the ALU controller.
- SrcA  input  DATA_WIDTH  operand A.
- SrcB  input  DATA_WIDTH  operand B, or the shift amount in its low bits.
- out_valid  output  1  result is available.
- out_ready  input  1  downstream accepts the result.
- ALUResult  output  DATA_WIDTH  registered result.
- Zero  output  1  high when ALUResult == 0 (branch compare).
- busy  output  1  a serial shift is in progress.

Behaviour:
- Operation encoding (decided):
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SLL
  - 0101 SRL
  - 0110 SUB
  - 0111 SRA
  - 1000 EQ: result = (A==B) ? 0 : 1, so Zero=1 means taken
  - 1100 SLT: signed compare, result = {0…,A<B}
  - Any other code: result 0, completes as a one-cycle operation.
- ADD and SUB wrap modulo 2^DATA_WIDTH. No overflow or carry output.
- Reset values: state=IDLE, out_valid=0, ALUResult=0, Zero=1, busy=0, shift count=0.
- States:
  - IDLE: no shift in progress.
  - SHIFT: serial shift in progress.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational.
- A request is accepted when in_valid && in_ready at a rising edge.
- Non-shift accepted:
  - ALUResult and Zero are loaded at that edge.
  - out_valid=1 from the next cycle. Latency 1.
  - Back-to-back acceptance every cycle is allowed while out_ready=1.
- Shift accepted (SLL, SRL, SRA):
  - Latch A, op, and count = shamt.
  - If shamt==0: result=A loaded immediately, same latency as non-shift.
  - Otherwise go to SHIFT with busy=1.
- In SHIFT, each cycle:
  - Shift the working register by 1: SLL fills 0, SRL fills 0, SRA fills the MSB.
  - Decrement count.
  - When count reaches 1→0: load ALUResult, set out_valid=1, return to IDLE.
  - Total latency = shamt cycles from acceptance to out_valid (minimum 1).
- Output handshake:
  - out_valid and ALUResult are held stable until out_valid && out_ready.
  - On acceptance of the output with no new request, out_valid drops next cycle.
  - Simultaneous output acceptance and new request acceptance: the new result replaces the old one with out_valid staying 1.
- Inputs are ignored while in_ready=0. Operands need not be held after acceptance.
- in_valid dropping mid-shift has no effect on the shift.
- Reset mid-shift: the shift is aborted, all outputs return to their reset values next edge, and no result is produced.
- out_ready asserted with out_valid=0: ignored.

Optional Feature:
- Macro: ALU_FAST_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter. Every operation has latency 1, the SHIFT state is never entered, and busy is tied to 0.
- Undefined: serial shifter as described above.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
- Reset mid-shift:
  - Stimulus: start SLL with A=1, B=20; assert reset at cycle 5.
  - Response: next cycle out_valid=0, ALUResult=0, Zero=1, busy=0, in_ready=1, and no result ever appears.
- Back-to-back non-shift ops with out_ready=1:
  - Stimulus: three requests with no gaps:
    - ADD 0xFFFFFFFF+1
    - SUB 5-7
    - SLT -3<2
  - Response: results on consecutive cycles:
    - 0x00000000 with Zero=1
    - 0xFFFFFFFE
    - 0x00000001
- SRA serial shift:
  - Stimulus: A=0x80000000, B=31.
  - Response:
    - in_ready=0 and busy=1 for 31 cycles.
    - ALUResult=0xFFFFFFFF and out_valid rise exactly 31 cycles after acceptance.
  - With ALU_FAST_SHIFT_EN: same result after 1 cycle.
- Shift by zero, and SRL with a masked shift amount:
  - Stimulus: SRL with A=0x1234, B=0x20 (shamt=0).
  - Response: ALUResult=0x1234 after 1 cycle; busy never asserts.
- Backpressure:
  - Stimulus: XOR 0xF0F0^0x0FF0 with out_ready=0 for 4 cycles.
  - Response:
    - ALUResult=0xFF00 held stable.
    - in_ready=0 while the output is held.
    - A new request on the cycle out_ready=1 is accepted and its result replaces the old one next cycle.
- EQ and undefined codes:
  - Stimulus: EQ with A=B=7, then code 1111.
  - Response:
    - EQ gives Zero=1, ALUResult=0.
    - Code 1111 gives ALUResult=0, Zero=1, latency 1.
